// File: rtl/local_mac_seq_if.sv
// local_mac_seq_if: controller-side request/result handshake and the
// word-line / partial-sum bus between local_mac_seq and one local_mac column.
interface local_mac_seq_if #(
  parameter int ACT_BITS = 8,
  parameter int MAC_W    = 15
);
  localparam int ACC_W = MAC_W + ACT_BITS + 1;

  logic                  start;
  logic [8*ACT_BITS-1:0] act_in;
  logic                  act_signed;
  logic                  w_signed;
  logic                  row_sel;
  logic                  busy;
  logic [7:0]            rwlb_row0;
  logic [7:0]            rwlb_row1;
  logic                  sus;
  logic [MAC_W-1:0]      mac_out;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_W-1:0]      result;

  modport slave (
    input  start, act_in, act_signed, w_signed, row_sel,
    input  mac_out, out_ready,
    output busy, rwlb_row0, rwlb_row1, sus, out_valid, result
  );

  modport master (
    output start, act_in, act_signed, w_signed, row_sel,
    output mac_out, out_ready,
    input  busy, rwlb_row0, rwlb_row1, sus, out_valid, result
  );
endinterface

// File: rtl/local_mac_seq.sv
// local_mac_seq: bit-serial activation sequencer for one local_mac column.
// Optional ZERO_SKIP_EN: all-zero bit planes accumulate 0 instead of mac_out.
module local_mac_seq #(
  parameter int ACT_BITS = 8,
  parameter int MAC_W    = 15
) (
  input logic           clk,
  input logic           rst,
  local_mac_seq_if.slave bus
);
  localparam int ACC_W = MAC_W + ACT_BITS + 1;
  localparam int CW    = $clog2(ACT_BITS);
  localparam logic [CW-1:0] CNT_TOP = CW'(ACT_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [8*ACT_BITS-1:0] act_q, act_d;
  logic                  act_s_q, act_s_d;
  logic                  row_q, row_d;
  logic                  sus_q, sus_d;
  logic                  vld_q, vld_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [ACC_W-1:0]      res_q, res_d;
  logic [7:0]            rwlb0_q, rwlb0_d;
  logic [7:0]            rwlb1_q, rwlb1_d;

  logic [7:0]            cur_pl;
  logic [7:0]            nxt_pl;
  logic [7:0]            start_pl;
  logic [ACC_W-1:0]      ext;
  logic [ACC_W-1:0]      acc_nx;

  // plane k = {lane7[k], ..., lane0[k]}
  function automatic logic [7:0] plane(
    input logic [8*ACT_BITS-1:0] a,
    input logic [CW-1:0]         k
  );
    logic [7:0] p;
    for (int j = 0; j < 8; j++) begin
      p[j] = a[j*ACT_BITS + int'(k)];
    end
    return p;
  endfunction

  assign cur_pl   = plane(act_q, cnt_q);
  assign nxt_pl   = plane(act_q, cnt_q - CW'(1));
  assign start_pl = plane(bus.act_in, CNT_TOP);

  always_comb begin
    ext = {{(ACC_W-MAC_W){sus_q & bus.mac_out[MAC_W-1]}},
           bus.mac_out};
`ifdef ZERO_SKIP_EN
    if (cur_pl == 8'h00) begin
      ext = '0;
    end
`endif
    // MSB plane carries negative weight for signed activations
    if (cnt_q == CNT_TOP) begin
      acc_nx = act_s_q ? (~ext + ACC_W'(1)) : ext;
    end else begin
      acc_nx = {acc_q[ACC_W-2:0], 1'b0} + ext;
    end
  end

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    act_s_d = act_s_q;
    row_d   = row_q;
    sus_d   = sus_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    rwlb0_d = rwlb0_q;
    rwlb1_d = rwlb1_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          act_d   = bus.act_in;
          act_s_d = bus.act_signed;
          row_d   = bus.row_sel;
          sus_d   = bus.w_signed;
          cnt_d   = CNT_TOP;
          rwlb0_d = bus.row_sel ? 8'hFF : ~start_pl;
          rwlb1_d = bus.row_sel ? ~start_pl : 8'hFF;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_nx;
        if (cnt_q != '0) begin
          cnt_d   = cnt_q - CW'(1);
          rwlb0_d = row_q ? 8'hFF : ~nxt_pl;
          rwlb1_d = row_q ? ~nxt_pl : 8'hFF;
        end else begin
          res_d   = acc_nx;
          vld_d   = 1'b1;
          rwlb0_d = 8'hFF;
          rwlb1_d = 8'hFF;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      act_q   <= '0;
      act_s_q <= 1'b0;
      row_q   <= 1'b0;
      sus_q   <= 1'b0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      rwlb0_q <= 8'hFF;
      rwlb1_q <= 8'hFF;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      act_s_q <= act_s_d;
      row_q   <= row_d;
      sus_q   <= sus_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      rwlb0_q <= rwlb0_d;
      rwlb1_q <= rwlb1_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.rwlb_row0 = rwlb0_q;
  assign bus.rwlb_row1 = rwlb1_q;
  assign bus.sus       = sus_q;
  assign bus.out_valid = vld_q;
  assign bus.result    = res_q;
endmodule

// File: doc/local_mac_seq.md
Name: local_mac_seq

Overview:
- Bit-serial activation sequencer for one local_mac column.
- Latches eight ACT_BITS-wide activations, presents them MSB-first as one bit plane per cycle on the read word lines of the selected weight row, and captures the combinational 15-bit partial sum every cycle.
- Shift-accumulates the partial sums into a full-precision dot product and returns it through a valid/ready handshake.
- Sits between the macro-level controller and local_mac; one instance per MAC column.

Parameters:
- ACT_BITS, 8, activation precision; number of bit planes per operation (2..16).
- MAC_W, 15, width of the local_mac partial sum.
- ACC_W, MAC_W+ACT_BITS+1, accumulator and result width (derived; do not override).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  operation request; accepted only in IDLE.
- act_in  input  8*ACT_BITS  activations; lane j = act_in[j*ACT_BITS +: ACT_BITS]; sampled when start is accepted.
- act_signed  input  1  activations are two's complement; sampled with start.
- w_signed  input  1  weights are signed; sampled with start, drives sus.
- row_sel  input  1  weight row to read: 0 = row0 (wb0), 1 = row1 (wb1); sampled with start.
- busy  output  1  high in RUN and DONE.
- rwlb_row0  output  8  active-low word lines, row0; registered.
- rwlb_row1  output  8  active-low word lines, row1; registered.
- sus  output  1  signed/unsigned select to local_mac; registered.
- mac_out  input  MAC_W  partial sum from local_mac, combinational from rwlb/sus.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- result  output  ACC_W  signed dot product; stable while out_valid is high.

Behaviour:
- Reset values: state=IDLE; rwlb_row0 and rwlb_row1 = 8'hFF; sus=0; out_valid=0; busy=0; result=0; bit counter=0.
- IDLE -> RUN on start:
  - latch act_in, act_signed, w_signed, row_sel; sus <= w_signed; counter <= ACT_BITS-1.
  - Selected row rwlb <= ~(plane ACT_BITS-1), where plane k = {lane7[k],...,lane0[k]}; unselected row held at 8'hFF.
- RUN, each cycle with counter = k:
  - ext = MAC_W-bit mac_out sign-extended to ACC_W if sus, else zero-extended.
  - First plane (k = ACT_BITS-1): acc <= act_signed ? -ext : ext.
  - Other planes: acc <= (acc<<1) + ext.
  - If k>0: drive ~plane(k-1) on the selected row and decrement the counter.
  - If k==0: go to DONE; result <= final acc value; both rwlb rows <= 8'hFF; out_valid <= 1.
- Latency: out_valid rises exactly ACT_BITS cycles after the start-accept edge. Exactly one plane is driven per cycle, and mac_out is sampled in the same cycle its plane is driven.
- DONE: out_valid and result hold until out_ready=1 is sampled; then out_valid <= 0 and state returns to IDLE.
- Throughput: start in DONE (including the out_ready cycle) or in RUN is ignored, with no queueing. Back-to-back operations are separated by at least one IDLE cycle.
- act_in, row_sel and the signedness inputs are don't-care outside the accept cycle.
- Reset mid-operation: the synchronous reset values apply at the next edge; the partial result is discarded and out_valid is not raised.
- All-zero activations: result = 0, same latency.
- Overflow: impossible by construction of ACC_W.

Optional Feature:
- ZERO_SKIP_EN defined: when a bit plane is all zeros, the selected row's rwlb stays 8'hFF for that cycle (no word line fires, saving read energy) and the accumulate step uses ext = 0 instead of mac_out. Latency and results are unchanged.
- ZERO_SKIP_EN undefined: every plane is driven as ~plane, including all-zero planes, and mac_out is always used.

Test Plan:
- Bench model: mac_out = signed/unsigned sum of bit*weight across lanes.
- Weights row0 = 1, act all lanes 8'd255, unsigned, row_sel=0 -> result=2040; out_valid exactly 8 cycles after start; rwlb_row1 = 8'hFF throughout.
- Weights row1 = -1 (w_signed=1), act all 8'hFF with act_signed=1, row_sel=1 -> sus=1 during RUN; result = +8.
- Lane0 act=8'h80 signed, weight=3, other lanes 0 -> result=-384. Hold out_ready=0 for 5 cycles -> result and out_valid stable; start pulses during RUN and DONE are ignored.
- Assert rst at the 4th RUN cycle -> next cycle rwlb rows = 8'hFF, out_valid=0, busy=0. A new start then yields the correct result.
- ZERO_SKIP_EN with lane0=8'h01, others 0, weight 5 -> rwlb row0 = 8'hFF for 7 cycles, then 8'hFE for one cycle; result=5. Without the macro, the first 7 planes also drive 8'hFF (~0) and result=5.
- Random regression: 1000 operations, random weights, activations, signedness and row, random out_ready -> result matches the model every time.
